// File: rtl/universal_shift_register.sv
// Multi-lane shift/rotate/load/clear register with registered serial output and saturating fill counter.
// Latency: 1 cycle, and every output is a flop updated on the rising edge of clk.
// Backpressure: none; enable=0 freezes all state, and any mode sequence is accepted every cycle.
module universal_shift_register #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       serial_in,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    output logic [WIDTH*DEPTH-1:0] out,
    output logic [WIDTH-1:0]       serial_out,
    output logic [CW-1:0]          fill_count,
    output logic                   full
);

    localparam int            LW       = WIDTH * DEPTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_ROTR  = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    mode_e            op;
    logic [LW-1:0]    data_q;
    logic [LW-1:0]    data_n;
    logic [WIDTH-1:0] so_q;
    logic [WIDTH-1:0] so_n;
    logic [CW-1:0]    fc_q;
    logic [CW-1:0]    fc_n;
    logic [CW-1:0]    fc_inc;
    logic             full_q;

    assign op = mode_e'(mode);

    // Every write of a new lane counts towards the fill level, stopping at DEPTH.
    assign fc_inc = (fc_q == FULL_CNT) ? fc_q : fc_q + CW'(1);

    // Next-state selection; lane DEPTH-1 sits in the top WIDTH bits of the flat vector.
    always_comb begin
        data_n = data_q;
        so_n   = so_q;
        fc_n   = fc_q;
        case (op)
            MODE_SHR: begin
                data_n = {serial_in, data_q[LW-1:WIDTH]};
                so_n   = data_q[WIDTH-1:0];
                fc_n   = fc_inc;
            end
            MODE_SHL: begin
                data_n = {data_q[LW-WIDTH-1:0], serial_in};
                so_n   = data_q[LW-1 -: WIDTH];
                fc_n   = fc_inc;
            end
            MODE_ROTR: begin
                data_n = {data_q[WIDTH-1:0], data_q[LW-1:WIDTH]};
                so_n   = data_q[WIDTH-1:0];
            end
            MODE_ROTL: begin
                data_n = {data_q[LW-WIDTH-1:0], data_q[LW-1 -: WIDTH]};
                so_n   = data_q[LW-1 -: WIDTH];
            end
            MODE_LOAD: begin
                data_n = load_data;
                fc_n   = FULL_CNT;
            end
            MODE_CLEAR: begin
                data_n = '0;
                so_n   = '0;
                fc_n   = '0;
            end
            default: begin
                // MODE_HOLD and the reserved encoding leave everything as is.
                data_n = data_q;
            end
        endcase
    end

    // State register: reset wins over enable, and full is flopped alongside the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            so_q   <= '0;
            fc_q   <= '0;
            full_q <= 1'b0;
        end else if (enable) begin
            data_q <= data_n;
            so_q   <= so_n;
            fc_q   <= fc_n;
            full_q <= (fc_n == FULL_CNT);
        end
    end

    assign out        = data_q;
    assign serial_out = so_q;
    assign fill_count = fc_q;
    assign full       = full_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=1, DEPTH=8 (fill counter 4 bits)
    logic        a_reset, a_enable;
    logic [2:0]  a_mode;
    logic [0:0]  a_sin;
    logic [7:0]  a_ld;
    logic [7:0]  a_out;
    logic [0:0]  a_so;
    logic [3:0]  a_fc;
    logic        a_full;

    // Instance B: WIDTH=4, DEPTH=4 (fill counter 3 bits)
    logic        b_reset, b_enable;
    logic [2:0]  b_mode;
    logic [3:0]  b_sin;
    logic [15:0] b_ld;
    logic [15:0] b_out;
    logic [3:0]  b_so;
    logic [2:0]  b_fc;
    logic        b_full;

    int checks = 0;
    int errors = 0;

    universal_shift_register #(.WIDTH(1), .DEPTH(8)) dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .enable     (a_enable),
        .mode       (a_mode),
        .serial_in  (a_sin),
        .load_data  (a_ld),
        .out        (a_out),
        .serial_out (a_so),
        .fill_count (a_fc),
        .full       (a_full)
    );

    universal_shift_register #(.WIDTH(4), .DEPTH(4)) dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .enable     (b_enable),
        .mode       (b_mode),
        .serial_in  (b_sin),
        .load_data  (b_ld),
        .out        (b_out),
        .serial_out (b_so),
        .fill_count (b_fc),
        .full       (b_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus to instance A and sample after the edge.
    task automatic a_op(input logic rst, input logic en, input logic [2:0] m,
                        input logic s, input logic [7:0] ld);
        a_reset  = rst;
        a_enable = en;
        a_mode   = m;
        a_sin    = s;
        a_ld     = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic b_op(input logic rst, input logic en, input logic [2:0] m,
                        input logic [3:0] s, input logic [15:0] ld);
        b_reset  = rst;
        b_enable = en;
        b_mode   = m;
        b_sin    = s;
        b_ld     = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic a_state(input string tag, input logic [7:0] o, input logic so,
                           input logic [3:0] fc, input logic fl);
        check({tag, ".out"}, 32'(a_out), 32'(o));
        check({tag, ".so"},  32'(a_so),  32'(so));
        check({tag, ".fc"},  32'(a_fc),  32'(fc));
        check({tag, ".full"}, 32'(a_full), 32'(fl));
    endtask

    task automatic b_state(input string tag, input logic [15:0] o, input logic [3:0] so,
                           input logic [2:0] fc, input logic fl);
        check({tag, ".out"}, 32'(b_out), 32'(o));
        check({tag, ".so"},  32'(b_so),  32'(so));
        check({tag, ".fc"},  32'(b_fc),  32'(fc));
        check({tag, ".full"}, 32'(b_full), 32'(fl));
    endtask

    logic [6:0] shr_seq;

    initial begin
        a_reset = 1'b1; a_enable = 1'b1; a_mode = 3'b000; a_sin = 1'b0; a_ld = '0;
        b_reset = 1'b1; b_enable = 1'b1; b_mode = 3'b000; b_sin = '0;   b_ld = '0;

        // ---------------- instance A ----------------
        a_op(1, 1, 3'b000, 0, 8'h00);
        a_op(1, 1, 3'b000, 0, 8'h00);
        a_state("a_reset", 8'h00, 0, 4'd0, 0);

        // serial_in 1,1,0,1,0,1,1 applied in that order
        shr_seq = 7'b1101011;
        for (int i = 6; i >= 0; i--) begin
            a_op(0, 1, 3'b001, shr_seq[i], 8'h00);
            if (i == 6) a_state("a_shr_first", 8'h80, 0, 4'd1, 0);
        end
        a_state("a_shr7", 8'hD6, 0, 4'd7, 0);
        a_op(0, 1, 3'b001, 0, 8'h00);
        a_state("a_shr8", 8'h6B, 0, 4'd8, 1);
        a_op(0, 1, 3'b001, 1, 8'h00);
        a_state("a_shr_sat", 8'hB5, 1, 4'd8, 1);

        a_op(0, 1, 3'b101, 0, 8'hA5);
        a_state("a_load_a5", 8'hA5, 1, 4'd8, 1);
        a_op(0, 1, 3'b010, 1, 8'h00);
        a_state("a_shl", 8'h4B, 1, 4'd8, 1);

        a_op(0, 1, 3'b101, 0, 8'h81);
        a_op(0, 1, 3'b011, 0, 8'h00);
        a_state("a_rotr", 8'hC0, 1, 4'd8, 1);
        a_op(0, 1, 3'b101, 0, 8'h81);
        a_op(0, 1, 3'b100, 0, 8'h00);
        a_state("a_rotl", 8'h03, 1, 4'd8, 1);

        a_op(0, 1, 3'b101, 0, 8'h5A);
        for (int i = 0; i < 3; i++) a_op(0, 0, 3'b001, 1'(i), 8'h00);
        a_state("a_en0", 8'h5A, 1, 4'd8, 1);
        a_op(0, 1, 3'b111, 1, 8'hFF);
        a_state("a_rsvd", 8'h5A, 1, 4'd8, 1);
        a_op(0, 1, 3'b000, 1, 8'hFF);
        a_state("a_hold", 8'h5A, 1, 4'd8, 1);

        a_op(0, 1, 3'b110, 1, 8'hFF);
        a_state("a_clear", 8'h00, 0, 4'd0, 0);
        a_op(0, 1, 3'b001, 1, 8'h00);
        a_op(0, 1, 3'b011, 1, 8'h00);
        a_state("a_rot_keep_fc", 8'h40, 0, 4'd1, 0);

        a_op(0, 1, 3'b101, 0, 8'h81);
        a_op(0, 1, 3'b011, 0, 8'h00);
        a_op(1, 1, 3'b101, 0, 8'hFF);
        a_state("a_rst_vs_load", 8'h00, 0, 4'd0, 0);

        a_op(0, 1, 3'b001, 1, 8'h00);
        a_op(0, 1, 3'b001, 1, 8'h00);
        a_op(0, 1, 3'b001, 1, 8'h00);
        a_state("a_pre_rst", 8'hE0, 0, 4'd3, 0);
        a_op(1, 1, 3'b001, 1, 8'h00);
        a_state("a_rst_mid", 8'h00, 0, 4'd0, 0);
        a_op(0, 1, 3'b001, 1, 8'h00);
        a_state("a_after_rst", 8'h80, 0, 4'd1, 0);

        // ---------------- instance B ----------------
        b_op(1, 1, 3'b000, 4'h0, 16'h0);
        b_state("b_reset", 16'h0000, 4'h0, 3'd0, 0);
        b_op(0, 1, 3'b001, 4'h1, 16'h0);
        b_op(0, 1, 3'b001, 4'h2, 16'h0);
        b_op(0, 1, 3'b001, 4'h3, 16'h0);
        b_state("b_shr3", 16'h3210, 4'h0, 3'd3, 0);
        b_op(0, 1, 3'b001, 4'h4, 16'h0);
        b_state("b_shr4", 16'h4321, 4'h0, 3'd4, 1);
        b_op(0, 1, 3'b001, 4'h5, 16'h0);
        b_state("b_shr5", 16'h5432, 4'h1, 3'd4, 1);
        b_op(0, 1, 3'b100, 4'hF, 16'h0);
        b_state("b_rotl", 16'h4325, 4'h5, 3'd4, 1);
        b_op(0, 1, 3'b110, 4'hF, 16'hFFFF);
        b_state("b_clear", 16'h0000, 4'h0, 3'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
